gamepad_input_ctrl: RTL and testbench

//  Serial SNES-protocol gamepad reader: drives pad_latch/pad_clk, shifts in 16 active-low button bits once per frame.

---
 rtl/gamepad_pkg.sv | 50 +++++
 rtl/gamepad_input_ctrl_if.sv | 28 ++
 rtl/gamepad_input_ctrl_pad_bit_timer.sv | 39 +++
 rtl/gamepad_input_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gamepad_input_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/gamepad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gamepad_pkg: shared pad/input bit indices and poll FSM encodings   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gamepad_pkg;

  localparam int PAD_W = 16;
  localparam int IN_W  = 10;

  // Pad serial bit order
  localparam int PAD_B      = 0;
  localparam int PAD_Y      = 1;
  localparam int PAD_SELECT = 2;
  localparam int PAD_START  = 3;
  localparam int PAD_UP     = 4;
  localparam int PAD_DOWN   = 5;
  localparam int PAD_LEFT   = 6;
  localparam int PAD_RIGHT  = 7;
  localparam int PAD_A      = 8;
  localparam int PAD_X      = 9;
  localparam int PAD_L      = 10;
  localparam int PAD_R      = 11;

  // input_data bit positions
  localparam int IN_ATTACK = 9;
  localparam int IN_RIGHT  = 8;
  localparam int IN_LEFT   = 7;
  localparam int IN_DOWN   = 6;
  localparam int IN_UP     = 5;
  localparam int IN_B      = 4;
  localparam int IN_START  = 3;
  localparam int IN_SELECT = 2;
  localparam int IN_A      = 1;
  localparam int IN_Y      = 0;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LATCH    = 3'd1;
  localparam state_t ST_SHIFT_LO = 3'd2;
  localparam state_t ST_SHIFT_HI = 3'd3;
  localparam state_t ST_DONE     = 3'd4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gamepad_input_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gamepad_input_ctrl_if: pad pins and decoded-input bus              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface gamepad_input_ctrl_if;
  import gamepad_pkg::*;

  logic              frame_end;
  logic              pad_data;
  logic              pad_latch;
  logic              pad_clk;
  logic [IN_W-1:0]   input_data;
  logic [PAD_W-1:0]  buttons_raw;
  logic              input_valid;
  logic              busy;

  modport master (
    input  frame_end, pad_data,
    output pad_latch, pad_clk, input_data, buttons_raw, input_valid, busy
  );

  modport slave (
    output frame_end, pad_data,
    input  pad_latch, pad_clk, input_data, buttons_raw, input_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/gamepad_input_ctrl_pad_bit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pad_bit_timer: loadable down-counter, one-cycle expire at zero     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pad_bit_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] r_count;
  logic             r_armed;
  logic             w_expire;

  // Loading N-1 makes expire land on the Nth cycle of the phase
  assign w_expire = r_armed && (r_count == '0);
  assign expire   = w_expire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_armed <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_armed <= 1'b1;
    end else if (w_expire) begin
      r_armed <= 1'b0;
    end else if (r_armed) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gamepad_input_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gamepad_input_ctrl: SNES pad poller and input_data decoder         |
// | Optional macro OPPOSITE_DIR_FILTER_EN cancels opposing directions  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gamepad_input_ctrl
  import gamepad_pkg::*;
#(
  parameter int HALF_CYCLES  = 150,
  parameter int LATCH_CYCLES = 300
) (
  input  logic                clk,
  input  logic                reset,
  gamepad_input_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(max2(LATCH_CYCLES, HALF_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] C_LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HALF_LOAD  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [3:0]       C_LAST_BIT   = 4'd15;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_val;
  logic              w_expire;

  logic [3:0]        r_bit_idx;
  logic [PAD_W-1:0]  r_shreg;
  logic [PAD_W-1:0]  r_buttons_raw;
  logic [IN_W-1:0]   r_input_data;
  logic              r_input_valid;
  logic              r_prev_b;

  logic              w_pad_latch;
  logic              w_pad_clk;
  logic              w_busy;
  logic              w_up, w_down, w_left, w_right;
  logic [IN_W-1:0]   w_decoded;

  pad_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Timer reloads ride on the phase transitions
  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.frame_end) begin
          w_state_next = ST_LATCH;
          w_tmr_load   = 1'b1;
          w_tmr_val    = C_LATCH_LOAD;
        end
      end
      ST_LATCH: begin
        if (w_expire) begin
          w_state_next = ST_SHIFT_LO;
          w_tmr_load   = 1'b1;
          w_tmr_val    = C_HALF_LOAD;
        end
      end
      ST_SHIFT_LO: begin
        if (w_expire) begin
          w_state_next = ST_SHIFT_HI;
          w_tmr_load   = 1'b1;
          w_tmr_val    = C_HALF_LOAD;
        end
      end
      ST_SHIFT_HI: begin
        if (w_expire) begin
          if (r_bit_idx == C_LAST_BIT) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_SHIFT_LO;
            w_tmr_load   = 1'b1;
            w_tmr_val    = C_HALF_LOAD;
          end
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pad_latch = (r_state == ST_LATCH);
    w_pad_clk   = (r_state != ST_SHIFT_LO);
    w_busy      = (r_state != ST_IDLE);
  end

  always_comb begin
    w_up    = r_shreg[PAD_UP];
    w_down  = r_shreg[PAD_DOWN];
    w_left  = r_shreg[PAD_LEFT];
    w_right = r_shreg[PAD_RIGHT];
`ifdef OPPOSITE_DIR_FILTER_EN
    if (w_up && w_down) begin
      w_up   = 1'b0;
      w_down = 1'b0;
    end
    if (w_left && w_right) begin
      w_left  = 1'b0;
      w_right = 1'b0;
    end
`endif
    w_decoded            = '0;
    w_decoded[IN_ATTACK] = r_shreg[PAD_B] & ~r_prev_b;
    w_decoded[IN_RIGHT]  = w_right;
    w_decoded[IN_LEFT]   = w_left;
    w_decoded[IN_DOWN]   = w_down;
    w_decoded[IN_UP]     = w_up;
    w_decoded[IN_B]      = r_shreg[PAD_B];
    w_decoded[IN_START]  = r_shreg[PAD_START];
    w_decoded[IN_SELECT] = r_shreg[PAD_SELECT];
    w_decoded[IN_A]      = r_shreg[PAD_A];
    w_decoded[IN_Y]      = r_shreg[PAD_Y];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit_idx     <= '0;
      r_shreg       <= '0;
      r_buttons_raw <= '0;
      r_input_data  <= '0;
      r_input_valid <= 1'b0;
      r_prev_b      <= 1'b0;
    end else begin
      r_input_valid <= (r_state == ST_DONE);
      if (r_state == ST_IDLE && bus.frame_end)
        r_bit_idx <= '0;
      // Sample just before pad_clk rises; the pad is active-low
      if (r_state == ST_SHIFT_LO && w_expire)
        r_shreg[r_bit_idx] <= ~bus.pad_data;
      if (r_state == ST_SHIFT_HI && w_expire && r_bit_idx != C_LAST_BIT)
        r_bit_idx <= r_bit_idx + 4'd1;
      if (r_state == ST_DONE) begin
        r_buttons_raw <= r_shreg;
        r_input_data  <= w_decoded;
        r_prev_b      <= r_shreg[PAD_B];
      end
    end
  end

  assign bus.pad_latch   = w_pad_latch;
  assign bus.pad_clk     = w_pad_clk;
  assign bus.busy        = w_busy;
  assign bus.input_data  = r_input_data;
  assign bus.buttons_raw = r_buttons_raw;
  assign bus.input_valid = r_input_valid;

endmodule
`default_nettype wire

// File: tb/tb_gamepad_input_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gamepad_input_ctrl: pad model, scoreboard and protocol monitor  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_gamepad_input_ctrl;
  import gamepad_pkg::*;

  localparam int HALF     = 4;
  localparam int LATCH    = 8;
  localparam int POLL_LAT = 1 + LATCH + 32 * HALF + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gamepad_input_ctrl_if bus();

  gamepad_input_ctrl #(.HALF_CYCLES(HALF), .LATCH_CYCLES(LATCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad: parallel load while latched, shift on each pad_clk rise
  logic [15:0] pad_buttons = '0;
  logic [15:0] pad_sr      = '0;
  logic        pclk_q      = 1'b1;
  always @(posedge clk) begin
    if (bus.pad_latch)              pad_sr <= pad_buttons;
    else if (bus.pad_clk && !pclk_q) pad_sr <= {1'b0, pad_sr[15:1]};
    pclk_q <= bus.pad_clk;
  end
  assign bus.pad_data = ~pad_sr[0];

  typedef struct {
    logic [15:0] raw;
    logic [9:0]  data;
    int          t0;
  } exp_t;
  exp_t sbq[$];
  logic model_prev_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] ref_decode(input logic [15:0] b, input logic pb);
    logic up, down, left, right;
    up = b[4]; down = b[5]; left = b[6]; right = b[7];
`ifdef OPPOSITE_DIR_FILTER_EN
    if (up && down)    begin up = 1'b0;   down = 1'b0;  end
    if (left && right) begin left = 1'b0; right = 1'b0; end
`endif
    return {b[0] & ~pb, right, left, down, up, b[0], b[3], b[2], b[8], b[1]};
  endfunction

  // Monitor: scoreboard pops plus pad waveform timing
  initial begin
    exp_t e;
    logic prev_latch = 1'b0, prev_pclk = 1'b1, hi_armed = 1'b0;
    int latch_w = 0, lo_w = 0, hi_w = 0, rises = 0, latch_rises = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_latch = 1'b0; prev_pclk = 1'b1; hi_armed = 1'b0;
        latch_w = 0; lo_w = 0; hi_w = 0; rises = 0; latch_rises = 0;
      end else begin
        if (bus.pad_latch && !prev_latch) begin
          latch_rises++; rises = 0; latch_w = 1; hi_armed = 1'b0;
        end else if (bus.pad_latch) begin
          latch_w++;
        end
        if (!bus.pad_latch && prev_latch) check("latch_width", latch_w, LATCH);
        if (!bus.pad_clk && prev_pclk) begin
          if (hi_armed) check("clk_high_width", hi_w, HALF);
          lo_w = 1;
        end else if (!bus.pad_clk) begin
          lo_w++;
        end
        if (bus.pad_clk && !prev_pclk) begin
          check("clk_low_width", lo_w, HALF);
          rises++; hi_w = 1; hi_armed = 1'b1;
        end else if (bus.pad_clk) begin
          hi_w++;
        end
        prev_latch = bus.pad_latch;
        prev_pclk  = bus.pad_clk;
        if (bus.input_valid) begin
          if (sbq.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("buttons_raw", bus.buttons_raw, e.raw);
            check("input_data", bus.input_data, e.data);
            check("poll_latency", cyc - e.t0, POLL_LAT);
            check("clk_rises", rises, 16);
            check("latch_pulses", latch_rises, 1);
          end
          latch_rises = 0;
        end
      end
    end
  end

  task automatic pulse_fe();
    bus.frame_end = 1'b1;
    @(posedge clk); #1;
    bus.frame_end = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || bus.busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL poll_timeout: pending=%0d busy=%0b", sbq.size(), bus.busy);
      sbq.delete();
    end
  endtask

  // extra_at > 0 re-pulses frame_end so the DUT samples it that many cycles into the poll
  task automatic do_poll(input logic [15:0] b, input int extra_at);
    exp_t e;
    pad_buttons = b;
    e.raw  = b;
    e.data = ref_decode(b, model_prev_b);
    model_prev_b = b[0];
    @(posedge clk); #1;
    e.t0 = cyc;
    sbq.push_back(e);
    pulse_fe();
    if (extra_at > 0) begin
      repeat (extra_at - 1) @(posedge clk);
      #1;
      pulse_fe();
    end
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.frame_end = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pad_latch", bus.pad_latch, 0);
    check("rst_pad_clk", bus.pad_clk, 1);
    check("rst_input_data", bus.input_data, 0);
    check("rst_buttons_raw", bus.buttons_raw, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.input_valid, 0);
    reset = 1'b1;

    do_poll(16'h0090, 0);

    // Abort a poll with reset: nothing published, state back to idle
    pad_buttons = 16'h0F0F;
    @(posedge clk); #1;
    pulse_fe();
    repeat (20) @(posedge clk);
    #1;
    check("pre_abort_busy", bus.busy, 1);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pad_latch", bus.pad_latch, 0);
    check("abort_pad_clk", bus.pad_clk, 1);
    check("abort_input_data", bus.input_data, 0);
    check("abort_buttons_raw", bus.buttons_raw, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.input_valid, 0);
    reset = 1'b1;
    model_prev_b = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("post_abort_busy", bus.busy, 0);

    // B held across polls: attack edge only on the first
    do_poll(16'h0001, 0);
    do_poll(16'h0001, 0);
    do_poll(16'h0001, 0);

    // frame_end while busy and coincident with DONE
    do_poll(16'h0300, 20);
    do_poll(16'h0808, POLL_LAT - 1);

    do_poll(16'h0070, 0);
    do_poll(16'h00C0, 0);
    do_poll(16'h0000, 0);
    do_poll(16'hFFFF, 0);

    for (int i = 0; i < 10; i++)
      do_poll(16'($urandom_range(0, 65535)), (($urandom & 3) == 0) ? int'($urandom_range(2, 130)) : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
